// File: rtl/answer_ctrl_pkg.sv
// Shared game definitions: FSM encodings, request source codes and the legal answer range.
package answer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [1:0] SRC_START   = 2'd0;
    localparam logic [1:0] SRC_WIN     = 2'd1;
    localparam logic [1:0] SRC_TIMEOUT = 2'd2;

    localparam logic [3:0] ANSWER_MIN = 4'd1;
    localparam logic [3:0] ANSWER_MAX = 4'd8;

    function automatic logic answer_in_range(input logic [3:0] v);
        return (v >= ANSWER_MIN) && (v <= ANSWER_MAX);
    endfunction

endpackage

// File: rtl/answer_ctrl_req_arbiter.sv
// Pending-request store for start/win/timeout with a fixed-priority grant (start highest).
module req_arbiter
    import answer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_start_i,
    input  logic       set_win_i,
    input  logic       set_timeout_i,
    input  logic       low_en_i,
    input  logic       clr_i,
    output logic       grant_valid_o,
    output logic [1:0] grant_src_o
);

    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] set_vec;
    logic [2:0] req_vec;
    logic [2:0] sel_vec;
    logic [2:0] clr_vec;

    assign set_vec = {set_timeout_i, set_win_i, set_start_i};
    // Pulses arriving this cycle are grantable at once; win/timeout can be masked.
    assign req_vec = (pend_q | set_vec) & {low_en_i, low_en_i, 1'b1};

    always_comb begin
        grant_valid_o = |req_vec;
        grant_src_o   = SRC_START;
        sel_vec       = 3'b000;
        if (req_vec[0]) begin
            grant_src_o = SRC_START;
            sel_vec     = 3'b001;
        end else if (req_vec[1]) begin
            grant_src_o = SRC_WIN;
            sel_vec     = 3'b010;
        end else if (req_vec[2]) begin
            grant_src_o = SRC_TIMEOUT;
            sel_vec     = 3'b100;
        end
    end

    assign clr_vec = clr_i ? sel_vec : 3'b000;

    // A pulse landing on an already-pending bit being cleared stays queued; a pulse
    // served directly (bit not yet pending) is consumed by the clear.
    assign pend_d = (pend_q & ~clr_vec) | (set_vec & ~(clr_vec & ~pend_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/answer_ctrl.sv
// Answer-change controller: arbitrates game requests, handshakes with the random generator,
// filters illegal/repeated values with bounded retries and latches the new answer.
module answer_ctrl
    import answer_ctrl_pkg::*;
#(
    parameter int WAIT_MAX  = 8,
    parameter int RETRY_MAX = 3,
    parameter int NO_REPEAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_start,
    input  logic       req_win,
    input  logic       req_timeout,
    input  logic [3:0] rand_val,
    input  logic       rand_we,
    output logic       change_answer,
    output logic [3:0] answer,
    output logic       answer_valid,
    output logic [7:0] round_cnt,
    output logic [1:0] src_last,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state_o
);

    localparam int WW_RAW = $clog2(WAIT_MAX + 1);
    localparam int RW_RAW = $clog2(RETRY_MAX + 1);
    localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

    state_e        state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [3:0]    answer_q, answer_d;
    logic          valid_q, valid_d;
    logic [7:0]    round_q, round_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          rep_chk_q, rep_chk_d;

    logic          grant_valid;
    logic [1:0]    grant_src;
    logic          grant_clr;
    logic          low_en;
    logic          repeat_hit;
    logic          timeout_hit;
    logic          reject;

    req_arbiter u_arb (
        .clk           (clk),
        .rst           (rst),
        .set_start_i   (req_start),
        .set_win_i     (req_win),
        .set_timeout_i (req_timeout),
        .low_en_i      (low_en),
        .clr_i         (grant_clr),
        .grant_valid_o (grant_valid),
        .grant_src_o   (grant_src)
    );

    assign low_en      = (state_q != ST_ERR);
    // rep_chk_q remembers whether the answer was valid when this request left IDLE.
    assign repeat_hit  = (NO_REPEAT != 0) && rep_chk_q && (rand_val == answer_q);
    assign timeout_hit = (wait_q == WW'(WAIT_MAX - 1));

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        answer_d  = answer_q;
        valid_d   = valid_q;
        round_d   = round_q;
        wait_d    = wait_q;
        retry_d   = retry_q;
        rep_chk_d = rep_chk_q;
        grant_clr = 1'b0;
        reject    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d   = ST_REQ;
                    src_d     = grant_src;
                    grant_clr = 1'b1;
                    valid_d   = 1'b0;
                    rep_chk_d = valid_q;
                end
            end
            ST_REQ: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rand_we) begin
                    if (answer_in_range(rand_val) && !repeat_hit) begin
                        answer_d = rand_val;
                        valid_d  = 1'b1;
                        round_d  = round_q + 8'd1;
                        retry_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (timeout_hit) begin
                    reject = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
                if (reject) begin
                    if (retry_q < RW'(RETRY_MAX)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                // Only start is grantable here; win/timeout stay pending.
                if (grant_valid) begin
                    state_d   = ST_REQ;
                    src_d     = SRC_START;
                    grant_clr = 1'b1;
                    retry_d   = '0;
                    valid_d   = 1'b0;
                    rep_chk_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= SRC_START;
            answer_q  <= 4'd0;
            valid_q   <= 1'b0;
            round_q   <= 8'd0;
            wait_q    <= '0;
            retry_q   <= '0;
            rep_chk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            answer_q  <= answer_d;
            valid_q   <= valid_d;
            round_q   <= round_d;
            wait_q    <= wait_d;
            retry_q   <= retry_d;
            rep_chk_q <= rep_chk_d;
        end
    end

    assign change_answer = (state_q == ST_REQ);
    assign busy          = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign err           = (state_q == ST_ERR);
    assign answer        = answer_q;
    assign answer_valid  = valid_q;
    assign round_cnt     = round_q;
    assign src_last      = src_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_answer_ctrl.sv
// Directed self-checking bench for answer_ctrl with default parameters.
module tb_answer_ctrl;
    import answer_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       req_start;
    logic       req_win;
    logic       req_timeout;
    logic [3:0] rand_val;
    logic       rand_we;
    logic       change_answer;
    logic [3:0] answer;
    logic       answer_valid;
    logic [7:0] round_cnt;
    logic [1:0] src_last;
    logic       busy;
    logic       err;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int base;

    answer_ctrl #(.WAIT_MAX(8), .RETRY_MAX(3), .NO_REPEAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_start     (req_start),
        .req_win       (req_win),
        .req_timeout   (req_timeout),
        .rand_val      (rand_val),
        .rand_we       (rand_we),
        .change_answer (change_answer),
        .answer        (answer),
        .answer_valid  (answer_valid),
        .round_cnt     (round_cnt),
        .src_last      (src_last),
        .busy          (busy),
        .err           (err),
        .dbg_state_o   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (change_answer === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input logic [3:0] v);
        rand_val = v;
        rand_we  = 1'b1;
        step();
        rand_we  = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        step();
        gen(v);
    endtask

    initial begin
        rst = 1'b1; req_start = 0; req_win = 0; req_timeout = 0; rand_val = 0; rand_we = 0;
        step(); step();
        check("rst_answer", answer, 0);
        check("rst_valid", answer_valid, 0);
        check("rst_round", round_cnt, 0);
        check("rst_src", src_last, 0);
        check("rst_change", change_answer, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        step();

        // single start, generator answers 5 two cycles after the pulse
        base = pulse_cnt;
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        check("s_req_change", change_answer, 1);
        check("s_req_busy", busy, 1);
        check("s_req_src", src_last, SRC_START);
        check("s_req_valid", answer_valid, 0);
        step();
        check("s_wait_state", dbg_state, ST_WAIT);
        check("s_wait_change", change_answer, 0);
        gen(4'd5);
        check("s_answer", answer, 5);
        check("s_valid", answer_valid, 1);
        check("s_round", round_cnt, 1);
        check("s_busy", busy, 0);
        check("s_pulses", pulse_cnt - base, 1);

        // win + timeout together: win first, then timeout; range edges 8 and 1
        req_win = 1'b1; req_timeout = 1'b1;
        step();
        req_win = 1'b0; req_timeout = 1'b0;
        check("wt_src1", src_last, SRC_WIN);
        check("wt_valid_drop", answer_valid, 0);
        step();
        gen(4'd8);
        check("wt_answer8", answer, 8);
        check("wt_round2", round_cnt, 2);
        step();
        check("wt_state2", dbg_state, ST_REQ);
        check("wt_src2", src_last, SRC_TIMEOUT);
        step();
        gen(4'd1);
        check("wt_answer1", answer, 1);
        check("wt_round3", round_cnt, 3);

        // repeated value rejected, next distinct value latched
        load(4'd3);
        check("nr_answer3", answer, 3);
        check("nr_valid3", answer_valid, 1);
        base = pulse_cnt;
        load(4'd3);
        check("nr_retry_state", dbg_state, ST_REQ);
        check("nr_retry_change", change_answer, 1);
        check("nr_keep3", answer, 3);
        step();
        gen(4'd6);
        check("nr_answer6", answer, 6);
        check("nr_round5", round_cnt, 5);
        check("nr_pulses", pulse_cnt - base, 2);

        // retries exhausted: 0, wait timeout, 12, 0 -> ERR
        base = pulse_cnt;
        load(4'd0);
        check("er_rej0", dbg_state, ST_REQ);
        step();
        repeat (7) step();
        check("er_wait7", dbg_state, ST_WAIT);
        step();
        check("er_wait_to", dbg_state, ST_REQ);
        step();
        gen(4'd12);
        check("er_rej12", dbg_state, ST_REQ);
        step();
        gen(4'd0);
        check("er_state", dbg_state, ST_ERR);
        check("er_err", err, 1);
        check("er_valid", answer_valid, 0);
        check("er_busy", busy, 0);
        check("er_answer", answer, 6);
        check("er_pulses", pulse_cnt - base, 4);
        req_win = 1'b1;
        step();
        req_win = 1'b0;
        step();
        check("er_win_held", dbg_state, ST_ERR);
        check("er_win_nochg", change_answer, 0);
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        check("er_rec_state", dbg_state, ST_REQ);
        check("er_rec_src", src_last, SRC_START);
        check("er_rec_err", err, 0);
        step();
        gen(4'd4);
        check("er_rec_answer", answer, 4);
        check("er_rec_round", round_cnt, 6);
        step();
        check("er_win_state", dbg_state, ST_REQ);
        check("er_win_src", src_last, SRC_WIN);
        step();
        gen(4'd5);
        check("er_win_round", round_cnt, 7);

        // async reset mid-handshake, then stray rand_we ignored
        req_start = 1'b1;
        step();
        req_start = 1'b0;
        step();
        rand_val = 4'd9; rand_we = 1'b1;
        rst = 1'b1;
        #1;
        check("ar_state", dbg_state, ST_IDLE);
        check("ar_answer", answer, 0);
        check("ar_valid", answer_valid, 0);
        check("ar_round", round_cnt, 0);
        check("ar_busy", busy, 0);
        check("ar_change", change_answer, 0);
        rand_we = 1'b0;
        step();
        rst = 1'b0;
        gen(4'd5);
        check("ar_ign_answer", answer, 0);
        check("ar_ign_round", round_cnt, 0);
        step();
        check("ar_ign_state", dbg_state, ST_IDLE);
        check("ar_ign_change", change_answer, 0);

        // round counter wrap
        for (int i = 0; i < 255; i++) load(4'((i % 8) + 1));
        check("wr_255", round_cnt, 255);
        load(4'd8);
        check("wr_0", round_cnt, 0);
        check("wr_answer", answer, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/answer_ctrl.md
ANSWER_CTRL -- requirements
Module: answer_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 8, SHALL set the cycles allowed in WAIT for rand_we before a retry.
REQ-002 Parameter RETRY_MAX, default 3, SHALL set the retries per request before entering ERR.
REQ-003 Parameter NO_REPEAT, default 1, SHALL reject a new answer equal to the current answer when 1.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_start  input  1  new-game pulse; priority 0, highest.
REQ-007 req_win  input  1  correct-guess pulse; priority 1.
REQ-008 req_timeout  input  1  round-timer-expired pulse; priority 2, lowest.
REQ-009 rand_val  input  4  value from the random generator; legal range 1..8.
REQ-010 rand_we  input  1  generator write-enable pulse; rand_val is valid while it is high.
REQ-011 change_answer  output  1  one-cycle request pulse to the generator.
REQ-012 answer  output  4  current latched answer.
REQ-013 answer_valid  output  1  answer usable by the game logic.
REQ-014 round_cnt  output  8  count of completed answer loads.
REQ-015 src_last  output  2  source of the request in service: 0 start, 1 win, 2 timeout.
REQ-016 busy  output  1  high in REQ and WAIT.
REQ-017 err  output  1  sticky generator-failure flag.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT and ERR.
REQ-019 Each req_* pulse SHALL set its own pending bit; a set and a clear of the same bit in one cycle SHALL leave the bit set.
REQ-020 In IDLE with any pending bit set, the FSM SHALL go to REQ next cycle, serving the highest-priority pending bit, clearing it and loading src_last.
REQ-021 In REQ, change_answer SHALL be 1 for exactly one cycle, answer_valid SHALL be 0, and the wait counter SHALL be zeroed. The FSM SHALL then go to WAIT.
REQ-022 In WAIT, on rand_we with rand_val in 1..8, the FSM SHALL do the following and go to IDLE:
- latch answer;
- set answer_valid the next cycle;
- increment round_cnt modulo 256;
- zero the retry count.
This holds unless REQ-023 applies.
REQ-023 With NO_REPEAT=1, a rand_val equal to the previous answer, while answer_valid held before REQ, SHALL be treated as a rejection.
REQ-024 A rejection SHALL cause a retry. Rejections are:
- rand_we with rand_val 0 or 9..15;
- a repeated value under REQ-023;
- WAIT_MAX cycles in WAIT without rand_we.
REQ-025 On a retry, if the retry count is below RETRY_MAX, the FSM SHALL increment it and return to REQ. Otherwise it SHALL go to ERR.
REQ-026 In ERR, err SHALL be 1 and answer_valid SHALL be 0. win and timeout pending bits SHALL be held, not served.
REQ-027 req_start in ERR SHALL clear err and the retry count, and enter REQ with src_last=0.
REQ-028 rand_we outside WAIT SHALL be ignored.
REQ-029 Minimum request-to-load latency SHALL be 3 cycles: pulse to REQ, REQ to WAIT, and rand_we sampled in WAIT.

Reset
REQ-030 rst SHALL immediately force the following:
- state IDLE;
- all pending bits 0;
- change_answer 0, busy 0, err 0;
- answer 0, answer_valid 0;
- round_cnt 0, src_last 0;
- wait and retry counters 0.
This applies in any state, including mid-handshake.

Structure
REQ-031 State encodings, source codes (0/1/2) and the answer range limits 1 and 8 SHALL live in the shared game package.
REQ-032 One sub-module, req_arbiter, SHALL hold the three pending bits and the fixed-priority select, with grant/clear ports.

Verification
REQ-033 req_start pulse, generator returns 5 on rand_we two cycles later -> one change_answer pulse, answer=5, answer_valid=1, round_cnt=1, src_last=0.
REQ-034 req_win and req_timeout in the same cycle -> win served first (src_last=1), then a second REQ with src_last=2; round_cnt advances by 2.
REQ-035 answer=3 valid, next load returns 3 with NO_REPEAT=1 -> second change_answer pulse; a following 6 is latched.
REQ-036 rand_val=0, then no rand_we for 8 cycles, then 12, then 0, with RETRY_MAX=3 -> four change_answer pulses, then ERR with err=1. A later req_start recovers.
REQ-037 rst asserted in WAIT, mid-handshake -> all outputs zero at once; a rand_we after reset release is ignored.
REQ-038 255 loads followed by one more -> round_cnt wraps to 0.
